regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, the next-generation replacement for the single-write, two-read core register file. It sits between decode/issue and writeback of the RV32 pipeline. It provides N combinational read ports, M synchronous write ports with fixed priority, an x0 hard-zero, and busy bits for hazard detection. Same-cycle write-to-read bypass is optional.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers; power of two, ≥2; AW = log2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  busy bit of the addressed register, combinational
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  1  issue-time allocation of a destination register
- alloc_addr  in  AW  register being allocated
- flush  in  1  pipeline flush; clears all busy bits
- busy_vec  out  NREGS  full scoreboard, bit i = register i busy

## Operation
- Storage: NREGS×XLEN array plus an NREGS-bit busy vector.
- Register 0:
  - reads always return 0 and busy 0
  - writes and allocs to it are ignored
  - busy_vec[0] is constant 0
- Write (wr_en[j]=1, wr_addr≠0): the array entry takes wr_data[j] at the next edge. The same write clears that register's busy bit.
- Write collision (two enabled ports, same address): the highest-index port wins, for both the data and the busy clear.
- Alloc (alloc_en=1, alloc_addr≠0): sets the busy bit at the next edge.
- Busy update priority per register, highest first:
  1. reset
  2. flush (clear)
  3. alloc (set)
  4. write (clear)
- Consequences of that priority:
  - alloc and write to the same register in one cycle leaves it busy, because a new producer has been issued.
  - flush with alloc in the same cycle leaves everything clear.
  - flush never alters register data; writes still commit during a flush cycle.
- Read: rd_data[k] = array[rd_addr[k]], subject to bypass (see Configuration). rd_busy[k] = busy[rd_addr[k]], with no bypass on busy.
- Out-of-range addresses cannot occur, since NREGS = 2^AW.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, array, and write inputs when bypass is enabled).
- Write latency: 1 edge. Data is visible on reads in the following cycle; with bypass, also in the same cycle.
- Busy latency: 1 edge after alloc, write, or flush.
- Reset, sampled at the edge with reset=1:
  - all registers go to 0 and all busy bits to 0
  - rd_data = 0 and rd_busy = 0 for every port the cycle after
  - wr_en, alloc_en and flush are ignored in that cycle
- Reset asserted mid-operation (e.g. writes pending on all ports) discards them. No partial state survives.

## Configuration
- REGFILE_BYPASS_EN defined:
  - when enabled writes are active, a read port whose address matches an enabled write with wr_addr≠0 returns that wr_data in the same cycle
  - if several ports match, the highest-index one is returned
  - address 0 is never bypassed
- REGFILE_BYPASS_EN undefined: reads return only the array contents, so a write is observed on the cycle after its edge.
- Busy bits behave identically in both builds.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert reset one cycle together with wr_en to x7 → all reads return 0, busy_vec=0, x7 stays 0.
- x0 protection: write 0x12345678 to x0 and alloc x0 → rd_data for address 0 is 0, busy_vec[0]=0.
- Port collision: wr_en=2'b11, both ports address x3, data 0xAAAA0000 on port 0 and 0x5555FFFF on port 1 → x3 reads 0x5555FFFF.
- Bypass: write 0xCAFEF00D to x9 on port 0 while reading x9 on port 1 → same-cycle rd_data is 0xCAFEF00D with REGFILE_BYPASS_EN, the old value without it; next cycle it is 0xCAFEF00D in both builds.
- Scoreboard: alloc x4 → rd_busy=1 next cycle. Then write x4 and alloc x4 in the same cycle → still busy. Then write x4 alone → busy 0.
- Flush: alloc x1, x2, x31 on consecutive cycles, then flush together with alloc x6 → busy_vec=0 the next cycle, and register data is unchanged.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard; REGFILE_BYPASS_EN adds same-cycle write-to-read bypass
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 flush,
  output logic [NREGS-1:0]     busy_vec
);
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != '0) busy_d[alloc_addr] = 1'b1;
    if (flush) busy_d = '0;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k*XLEN +: XLEN] = regs_q[rd_addr[k*AW +: AW]];
      rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0 && wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])
          rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
`endif
    end
  end
  assign busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of reset, x0, collisions, bypass, scoreboard and flush
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        flush;
  logic [31:0] busy_vec;
  int tests = 0;
  int fails = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); reset = 1'b1; rd_addr = '0;
    tick(); tick();
    idle();
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_init busy_vec=%h exp=0", busy_vec); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    alloc_en = 1'b1; alloc_addr = 5'd8;
    tick(); idle();
    rd_addr = {5'd8, 5'd5}; #1;
    tests++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_prewrite x5=%h exp=deadbeef", rd_data[31:0]); end
    reset = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h00000077};
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick(); idle();
    rd_addr = {5'd7, 5'd5}; #1;
    tests++;
    if (rd_data !== 64'h0) begin fails++; $display("FAIL reset_data x5/x7=%h exp=0", rd_data); end
    tests++;
    if (busy_vec !== 32'h0 || rd_busy !== 2'b00) begin fails++; $display("FAIL reset_busy busy_vec=%h rd_busy=%b exp=0", busy_vec, rd_busy); end
  endtask

  task automatic test_x0();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h12345678};
    alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr = {5'd0, 5'd0}; #1;
    tests++;
    if (rd_data !== 64'h0) begin fails++; $display("FAIL x0_same_cycle rd=%h exp=0", rd_data); end
    tick(); idle(); #1;
    tests++;
    if (rd_data !== 64'h0) begin fails++; $display("FAIL x0_data rd=%h exp=0", rd_data); end
    tests++;
    if (busy_vec !== 32'h0 || rd_busy !== 2'b00) begin fails++; $display("FAIL x0_busy busy_vec=%h rd_busy=%b exp=0", busy_vec, rd_busy); end
  endtask

  task automatic test_collision();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick(); idle();
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h5555FFFF, 32'hAAAA0000};
    tick(); idle();
    rd_addr = {5'd0, 5'd3}; #1;
    tests++;
    if (rd_data[31:0] !== 32'h5555FFFF) begin fails++; $display("FAIL collision_data x3=%h exp=5555ffff", rd_data[31:0]); end
    tests++;
    if (rd_busy[0] !== 1'b0) begin fails++; $display("FAIL collision_busy rd_busy=%b exp=0", rd_busy[0]); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h01020304};
    tick(); idle(); #1;
    tests++;
    if (rd_data[31:0] !== 32'h01020304) begin fails++; $display("FAIL port0_write x3=%h exp=01020304", rd_data[31:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h11111111, 32'h0};
    tick(); idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hCAFEF00D};
    rd_addr = {5'd9, 5'd8}; #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hCAFEF00D;
`else
    exp = 32'h11111111;
`endif
    tests++;
    if (rd_data[63:32] !== exp) begin fails++; $display("FAIL bypass_same rd1=%h exp=%h", rd_data[63:32], exp); end
    tests++;
    if (rd_data[31:0] !== 32'h0) begin fails++; $display("FAIL bypass_other rd0=%h exp=0", rd_data[31:0]); end
    tick(); idle(); #1;
    tests++;
    if (rd_data[63:32] !== 32'hCAFEF00D) begin fails++; $display("FAIL bypass_next rd1=%h exp=cafef00d", rd_data[63:32]); end
    wr_en = 2'b11; wr_addr = {5'd10, 5'd10}; wr_data = {32'hBBBB0002, 32'hAAAA0001};
    rd_addr = {5'd10, 5'd10}; #1;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hBBBB0002;
`else
    exp = 32'h0;
`endif
    tests++;
    if (rd_data !== {exp, exp}) begin fails++; $display("FAIL bypass_multi rd=%h exp=%h%h", rd_data, exp, exp); end
    tick(); idle(); #1;
    tests++;
    if (rd_data !== {32'hBBBB0002, 32'hBBBB0002}) begin fails++; $display("FAIL multi_next rd=%h exp=bbbb0002", rd_data); end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd0, 5'd4};
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick(); idle(); #1;
    tests++;
    if (rd_busy[0] !== 1'b1 || busy_vec !== 32'h00000010) begin fails++; $display("FAIL sb_alloc rd_busy=%b busy_vec=%h exp=1/00000010", rd_busy[0], busy_vec); end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44440001};
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick(); idle(); #1;
    tests++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h44440001) begin fails++; $display("FAIL sb_alloc_write rd_busy=%b x4=%h exp=1/44440001", rd_busy[0], rd_data[31:0]); end
    wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44440002, 32'h0}; #1;
    tests++;
    if (rd_busy[0] !== 1'b1) begin fails++; $display("FAIL sb_no_busy_bypass rd_busy=%b exp=1", rd_busy[0]); end
    tick(); idle(); #1;
    tests++;
    if (rd_busy[0] !== 1'b0 || busy_vec !== 32'h0) begin fails++; $display("FAIL sb_write_clear rd_busy=%b busy_vec=%h exp=0", rd_busy[0], busy_vec); end
  endtask

  task automatic test_flush();
    alloc_en = 1'b1; alloc_addr = 5'd1; tick();
    alloc_addr = 5'd2; tick();
    alloc_addr = 5'd31; tick(); idle(); #1;
    tests++;
    if (busy_vec !== 32'h80000006) begin fails++; $display("FAIL flush_pre busy_vec=%h exp=80000006", busy_vec); end
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd6;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {32'h0, 32'h00000077};
    tick(); idle();
    rd_addr = {5'd20, 5'd4}; #1;
    tests++;
    if (busy_vec !== 32'h0) begin fails++; $display("FAIL flush_busy busy_vec=%h exp=0", busy_vec); end
    tests++;
    if (rd_data !== {32'h00000077, 32'h44440002}) begin fails++; $display("FAIL flush_data rd=%h exp=0000007744440002", rd_data); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
